// File: rtl/l2_refill_scheduler.sv
// Read-path sequencer for the dual-ported L2 buffer: arbitrates DDR refills
// against L1 burst drains and drives the L2 port controls.
`timescale 1ns/1ps

module l2_refill_scheduler #(
  parameter int unsigned L1_BURST_LEN  = 8,
  parameter int unsigned DDR_BURST_LEN = 4,
  parameter int unsigned LOW_WATERMARK = 64
) (
  input  logic        clk_166M66,
  input  logic        i_rst_n,
  input  logic [11:0] i_l2_unread_size,
  input  logic        i_l1ddr_rw_confilicts,
  input  logic        i_l1_req,
  input  logic [11:0] i_l1_req_address,
  output logic        o_l1_ack,
  output logic        o_l1_burst_done,
  output logic        o_ddr_req,
  input  logic        i_ddr_grant,
  input  logic        i_ddr_data_valid,
  output logic [11:0] o_l2_l1_burst_address,
  output logic        o_l2_l1_burst_address_enable,
  output logic        o_l2_l1_operate_enable,
  output logic        o_l2_l1_rw,
  output logic        o_l2_ddr_operate_enable,
  output logic        o_l2_ddr_rw,
  output logic        o_busy
);

  // state      | meaning
  // IDLE       | arbitration; decision captured, acted on next edge
  // CHECK      | burst address presented for the L1/DDR conflict check
  // L1_BURST   | L1 port draining L1_BURST_LEN words
  // DDR_WAIT   | refill requested, waiting for grant
  // FILL       | DDR port writing DDR_BURST_LEN beats into L2
  typedef enum logic [2:0] {
    S_IDLE, S_CHECK, S_L1_BURST, S_DDR_WAIT, S_FILL
  } state_t;

  typedef enum logic [1:0] {P_NONE, P_L1, P_REFILL} pend_t;

  localparam logic [11:0] REFILL_SPACE = 12'(DDR_BURST_LEN * 8);
  localparam logic [11:0] WATERMARK    = 12'(LOW_WATERMARK);
  localparam logic [11:0] L1_LEN       = 12'(L1_BURST_LEN);
  localparam logic [7:0]  BEAT_LAST    = 8'(L1_BURST_LEN - 1);
  localparam logic [5:0]  FILL_LAST    = 6'(DDR_BURST_LEN - 1);

  state_t      state_q, state_d;
  pend_t       pend_q, pend_d;
  logic [7:0]  beat_q, beat_d;
  logic [5:0]  fill_q, fill_d;
  logic [11:0] addr_q, addr_d;
  logic        ack_q, ack_d;
  logic        done_q, done_d;
  logic        ddr_req_q, ddr_req_d;
  logic        addr_en_q, addr_en_d;
  logic        l1_op_q, l1_op_d;
  logic        ddr_rw_q, ddr_rw_d;
  logic        busy_q, busy_d;

  logic [11:0] free_words;
  logic        refill_elig;
  logic        l1_elig;

  always_comb begin
    free_words  = 12'hFFF - i_l2_unread_size;
    refill_elig = (i_l2_unread_size < WATERMARK) && (free_words >= REFILL_SPACE);
    l1_elig     = i_l1_req && (i_l2_unread_size >= L1_LEN);

    state_d = state_q;
    pend_d  = P_NONE;
    beat_d  = beat_q;
    fill_d  = fill_q;
    addr_d  = addr_q;

    unique case (state_q)
      S_IDLE: begin
        // Arbitration result is registered first, so IDLE always spans a sample edge
        unique case (pend_q)
          P_REFILL: state_d = S_DDR_WAIT;
          P_L1: begin
            state_d = S_CHECK;
            addr_d  = i_l1_req_address;
          end
          default: pend_d = refill_elig ? P_REFILL : (l1_elig ? P_L1 : P_NONE);
        endcase
      end
      S_CHECK: begin
        if (!i_l1ddr_rw_confilicts) begin
          state_d = S_L1_BURST;
          beat_d  = BEAT_LAST;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_L1_BURST: begin
        if (beat_q == 8'd0) state_d = S_IDLE;
        else                beat_d  = beat_q - 8'd1;
      end
      S_DDR_WAIT: begin
        if (i_ddr_grant) begin
          state_d = S_FILL;
          fill_d  = FILL_LAST;
        end
      end
      S_FILL: begin
        if (i_ddr_data_valid) begin
          if (fill_q == 6'd0) state_d = S_IDLE;
          else                fill_d  = fill_q - 6'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Outputs are decoded from the next state so they line up with state_q
    ack_d     = (state_q == S_CHECK) && (state_d == S_L1_BURST);
    done_d    = (state_d == S_L1_BURST) && (beat_d == 8'd0);
    addr_en_d = (state_d == S_CHECK);
    l1_op_d   = (state_d == S_L1_BURST);
    ddr_req_d = (state_d == S_DDR_WAIT);
    ddr_rw_d  = (state_d == S_FILL);
    busy_d    = (state_d != S_IDLE);
  end

  always_ff @(posedge clk_166M66) begin
    if (!i_rst_n) begin
      state_q   <= S_IDLE;
      pend_q    <= P_NONE;
      beat_q    <= 8'd0;
      fill_q    <= 6'd0;
      addr_q    <= 12'h000;
      ack_q     <= 1'b0;
      done_q    <= 1'b0;
      ddr_req_q <= 1'b0;
      addr_en_q <= 1'b0;
      l1_op_q   <= 1'b0;
      ddr_rw_q  <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      pend_q    <= pend_d;
      beat_q    <= beat_d;
      fill_q    <= fill_d;
      addr_q    <= addr_d;
      ack_q     <= ack_d;
      done_q    <= done_d;
      ddr_req_q <= ddr_req_d;
      addr_en_q <= addr_en_d;
      l1_op_q   <= l1_op_d;
      ddr_rw_q  <= ddr_rw_d;
      busy_q    <= busy_d;
    end
  end

  assign o_l1_ack                     = ack_q;
  assign o_l1_burst_done              = done_q;
  assign o_ddr_req                    = ddr_req_q;
  assign o_l2_l1_burst_address        = addr_q;
  assign o_l2_l1_burst_address_enable = addr_en_q;
  assign o_l2_l1_operate_enable       = l1_op_q;
  assign o_l2_l1_rw                   = 1'b0;
  assign o_l2_ddr_rw                  = ddr_rw_q;
  assign o_busy                       = busy_q;
  // DDR port follows beat-valid directly so no beat is lost to a register stage
  assign o_l2_ddr_operate_enable      = ddr_rw_q & i_ddr_data_valid;

endmodule

// File: tb/tb_l2_refill_scheduler.sv
// Directed bench for l2_refill_scheduler: reset, refill with gaps, L1 bursts,
// conflict retry, refill priority, mid-burst reset and the 4095 boundary.
`timescale 1ns/1ps

module tb_l2_refill_scheduler;
  logic        clk_166M66 = 1'b0;
  logic        i_rst_n;
  logic [11:0] i_l2_unread_size;
  logic        i_l1ddr_rw_confilicts;
  logic        i_l1_req;
  logic [11:0] i_l1_req_address;
  logic        o_l1_ack;
  logic        o_l1_burst_done;
  logic        o_ddr_req;
  logic        i_ddr_grant;
  logic        i_ddr_data_valid;
  logic [11:0] o_l2_l1_burst_address;
  logic        o_l2_l1_burst_address_enable;
  logic        o_l2_l1_operate_enable;
  logic        o_l2_l1_rw;
  logic        o_l2_ddr_operate_enable;
  logic        o_l2_ddr_rw;
  logic        o_busy;

  int errors = 0;
  int checks = 0;
  int n_op;
  logic [4:0] pat;

  always #3 clk_166M66 = ~clk_166M66;

  l2_refill_scheduler dut (
    .clk_166M66                   (clk_166M66),
    .i_rst_n                      (i_rst_n),
    .i_l2_unread_size             (i_l2_unread_size),
    .i_l1ddr_rw_confilicts        (i_l1ddr_rw_confilicts),
    .i_l1_req                     (i_l1_req),
    .i_l1_req_address             (i_l1_req_address),
    .o_l1_ack                     (o_l1_ack),
    .o_l1_burst_done              (o_l1_burst_done),
    .o_ddr_req                    (o_ddr_req),
    .i_ddr_grant                  (i_ddr_grant),
    .i_ddr_data_valid             (i_ddr_data_valid),
    .o_l2_l1_burst_address        (o_l2_l1_burst_address),
    .o_l2_l1_burst_address_enable (o_l2_l1_burst_address_enable),
    .o_l2_l1_operate_enable       (o_l2_l1_operate_enable),
    .o_l2_l1_rw                   (o_l2_l1_rw),
    .o_l2_ddr_operate_enable      (o_l2_ddr_operate_enable),
    .o_l2_ddr_rw                  (o_l2_ddr_rw),
    .o_busy                       (o_busy)
  );

  task automatic chk(input string tag, input logic [11:0] obs, input logic [11:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_166M66);
    #1;
  endtask

  initial begin
    i_rst_n = 1'b0;
    i_l2_unread_size = 12'd0;
    i_l1ddr_rw_confilicts = 1'b0;
    i_l1_req = 1'b0;
    i_l1_req_address = 12'h000;
    i_ddr_grant = 1'b0;
    i_ddr_data_valid = 1'b0;
    repeat (3) tick();

    chk("rst_busy", o_busy, 0);
    chk("rst_ddr_req", o_ddr_req, 0);
    chk("rst_l1_op", o_l2_l1_operate_enable, 0);
    chk("rst_ddr_op", o_l2_ddr_operate_enable, 0);
    chk("rst_addr_en", o_l2_l1_burst_address_enable, 0);
    chk("rst_addr", o_l2_l1_burst_address, 12'h000);
    chk("rst_ack", o_l1_ack, 0);
    chk("rst_done", o_l1_burst_done, 0);
    chk("rst_l1_rw", o_l2_l1_rw, 0);
    chk("rst_ddr_rw", o_l2_ddr_rw, 0);

    // Refill after reset release; grant on the third request cycle
    i_rst_n = 1'b1;
    tick();
    chk("rel_req_sample", o_ddr_req, 0);
    tick();
    chk("rel_ddr_req", o_ddr_req, 1);
    chk("rel_busy", o_busy, 1);
    i_l2_unread_size = 12'd100;
    tick();
    chk("wait_ddr_req", o_ddr_req, 1);
    i_ddr_grant = 1'b1;
    tick();
    i_ddr_grant = 1'b0;
    chk("grant_req_drop", o_ddr_req, 0);
    chk("fill_rw", o_l2_ddr_rw, 1);
    pat = 5'b11101;
    n_op = 0;
    for (int i = 0; i < 5; i++) begin
      i_ddr_data_valid = pat[i];
      #1;
      chk("fill_op", o_l2_ddr_operate_enable, pat[i]);
      chk("fill_rw_hold", o_l2_ddr_rw, 1);
      chk("fill_no_l1", o_l2_l1_operate_enable, 0);
      if (o_l2_ddr_operate_enable) n_op++;
      tick();
    end
    chk("fill_op_count", 12'(n_op), 12'd4);
    chk("fill_end_busy", o_busy, 0);
    chk("fill_end_rw", o_l2_ddr_rw, 0);
    chk("dv_ignored_idle", o_l2_ddr_operate_enable, 0);
    i_ddr_data_valid = 1'b0;

    // L1 burst, no conflict
    i_l1_req = 1'b1;
    i_l1_req_address = 12'h040;
    tick();
    chk("l1_sample_addr_en", o_l2_l1_burst_address_enable, 0);
    tick();
    chk("chk_addr_en", o_l2_l1_burst_address_enable, 1);
    chk("chk_addr", o_l2_l1_burst_address, 12'h040);
    chk("chk_busy", o_busy, 1);
    chk("chk_no_op", o_l2_l1_operate_enable, 0);
    tick();
    chk("burst_addr_en_off", o_l2_l1_burst_address_enable, 0);
    i_l1_req = 1'b0;
    i_l1_req_address = 12'h000;
    for (int b = 1; b <= 8; b++) begin
      chk("burst_op", o_l2_l1_operate_enable, 1);
      chk("burst_ack", o_l1_ack, (b == 1) ? 12'd1 : 12'd0);
      chk("burst_done", o_l1_burst_done, (b == 8) ? 12'd1 : 12'd0);
      chk("burst_rw", o_l2_l1_rw, 0);
      chk("burst_no_ddr", o_l2_ddr_operate_enable, 0);
      tick();
    end
    chk("burst_end_op", o_l2_l1_operate_enable, 0);
    chk("burst_end_done", o_l1_burst_done, 0);
    chk("burst_end_busy", o_busy, 0);
    chk("addr_held", o_l2_l1_burst_address, 12'h040);

    // Conflict on first attempt, retry succeeds
    i_l1_req = 1'b1;
    i_l1_req_address = 12'h123;
    i_l1ddr_rw_confilicts = 1'b1;
    tick();
    tick();
    chk("cf_addr_en", o_l2_l1_burst_address_enable, 1);
    chk("cf_addr", o_l2_l1_burst_address, 12'h123);
    tick();
    chk("cf_no_ack", o_l1_ack, 0);
    chk("cf_no_op", o_l2_l1_operate_enable, 0);
    chk("cf_idle", o_busy, 0);
    i_l1ddr_rw_confilicts = 1'b0;
    tick();
    chk("retry_idle", o_busy, 0);
    tick();
    chk("retry_addr_en", o_l2_l1_burst_address_enable, 1);
    tick();
    chk("retry_ack", o_l1_ack, 1);
    i_l1_req = 1'b0;
    repeat (7) tick();
    chk("retry_done", o_l1_burst_done, 1);
    chk("retry_last_op", o_l2_l1_operate_enable, 1);
    tick();
    chk("retry_end_busy", o_busy, 0);

    // Refill wins over L1 when both eligible
    i_l2_unread_size = 12'd20;
    i_l1_req = 1'b1;
    i_l1_req_address = 12'h200;
    tick();
    tick();
    chk("prio_ddr_req", o_ddr_req, 1);
    chk("prio_no_addr_en", o_l2_l1_burst_address_enable, 0);
    i_ddr_grant = 1'b1;
    i_l2_unread_size = 12'd100;
    tick();
    i_ddr_grant = 1'b0;
    chk("prio_fill_rw", o_l2_ddr_rw, 1);
    i_ddr_data_valid = 1'b1;
    repeat (4) begin
      chk("prio_no_l1_op", o_l2_l1_operate_enable, 0);
      tick();
    end
    i_ddr_data_valid = 1'b0;
    chk("prio_fill_end", o_busy, 0);
    tick();
    chk("prio_idle_gap", o_busy, 0);
    tick();
    chk("prio_chk_addr_en", o_l2_l1_burst_address_enable, 1);
    chk("prio_chk_addr", o_l2_l1_burst_address, 12'h200);
    tick();
    chk("prio_ack", o_l1_ack, 1);
    i_l1_req = 1'b0;

    // Reset during the fifth beat
    repeat (4) tick();
    chk("beat5_op", o_l2_l1_operate_enable, 1);
    chk("beat5_no_done", o_l1_burst_done, 0);
    i_rst_n = 1'b0;
    tick();
    chk("mrst_op", o_l2_l1_operate_enable, 0);
    chk("mrst_busy", o_busy, 0);
    chk("mrst_done", o_l1_burst_done, 0);
    chk("mrst_addr", o_l2_l1_burst_address, 12'h000);
    i_rst_n = 1'b1;
    repeat (3) tick();
    chk("post_rst_idle", o_busy, 0);

    // Full buffer: no refill, L1 still eligible
    i_l2_unread_size = 12'hFFF;
    i_l1_req = 1'b1;
    i_l1_req_address = 12'h7FF;
    tick();
    tick();
    chk("full_no_refill", o_ddr_req, 0);
    chk("full_addr_en", o_l2_l1_burst_address_enable, 1);
    i_l1ddr_rw_confilicts = 1'b1;
    tick();
    chk("full_cf_idle", o_busy, 0);
    i_l1_req = 1'b0;
    i_l1ddr_rw_confilicts = 1'b0;
    repeat (3) tick();
    chk("full_stay_idle", o_busy, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/l2_refill_scheduler.md
# l2_refill_scheduler

Sequencer for the read path of the dual-ported L2 buffer. It decides, cycle by cycle, whether the L2 buffer's 128-bit DDR port is refilling from the DDR controller or its 16-bit L1 port is draining a burst to L1, and drives all L2 operate/rw/burst-address controls. Decisions use the L2 unread-size and L1/DDR conflict status. It sits between the L1 cache miss logic, the DDR controller, and the L2 buffer, all in the 166.66 MHz domain.

## Interface
Parameters:
- L1_BURST_LEN, 8: 16-bit words per L1 burst; range 1..255.
- DDR_BURST_LEN, 4: 128-bit beats per DDR refill; range 1..63.
- LOW_WATERMARK, 64: unread words below which a refill takes priority.

Ports:
- clk_166M66  in  1  sole clock.
- i_rst_n  in  1  reset, synchronous, active-low.
- i_l2_unread_size  in  12  unread 16-bit words currently in L2.
- i_l1ddr_rw_confilicts  in  1  L2 conflict flag; valid in the same cycle as the burst address.
- i_l1_req  in  1  L1 read-burst request; level, held until o_l1_ack.
- i_l1_req_address  in  12  L2 word address of the requested burst; stable while i_l1_req is high.
- o_l1_ack  out  1  one-cycle pulse on the first data cycle of the granted burst.
- o_l1_burst_done  out  1  one-cycle pulse on the last data cycle.
- o_ddr_req  out  1  refill request to the DDR controller.
- i_ddr_grant  in  1  DDR controller accepts the refill; one-cycle pulse.
- i_ddr_data_valid  in  1  one 128-bit beat is on the L2 DDR bus this cycle.
- o_l2_l1_burst_address  out  12  registered copy of i_l1_req_address.
- o_l2_l1_burst_address_enable  out  1  burst-address qualifier for the conflict check.
- o_l2_l1_operate_enable  out  1  L1-port enable.
- o_l2_l1_rw  out  1  L1-port direction; constant 0 (read).
- o_l2_ddr_operate_enable  out  1  DDR-port enable.
- o_l2_ddr_rw  out  1  DDR-port direction; 1 (write into L2) while in FILL, otherwise 0.
- o_busy  out  1  high in any state other than IDLE.

## Operation
- FSM states: IDLE, CHECK, L1_BURST, DDR_WAIT, FILL. The two L2 ports are never enabled in the same cycle.
- Free space is computed as 4095 − i_l2_unread_size, in 12 bits with no wrap. A refill is eligible when i_l2_unread_size < LOW_WATERMARK and free ≥ DDR_BURST_LEN×8.
- L1 service is eligible when i_l1_req = 1 and i_l2_unread_size ≥ L1_BURST_LEN.
- IDLE transitions:
  - If a refill is eligible, go to DDR_WAIT.
  - Otherwise, if L1 service is eligible, go to CHECK.
  - Otherwise, stay in IDLE.
  - A refill always wins when both are eligible.
- CHECK: lasts exactly one cycle, with o_l2_l1_burst_address_enable = 1 and the address latched.
  - If i_l1ddr_rw_confilicts = 0, go to L1_BURST.
  - If the conflict flag is set, return to IDLE with no ack. The request is retried by normal arbitration.
- L1_BURST:
  - o_l2_l1_operate_enable = 1 for exactly L1_BURST_LEN cycles, counted by an 8-bit beat counter.
  - o_l1_ack pulses on the first of these cycles; o_l1_burst_done pulses on the last.
  - Then go to IDLE. A burst is never aborted once started.
- DDR_WAIT: o_ddr_req = 1 until i_ddr_grant is sampled high; go to FILL on the next cycle, with o_ddr_req low.
- FILL:
  - o_l2_ddr_operate_enable = i_ddr_data_valid. This is the only combinational output path; all other outputs are registered.
  - A 6-bit counter counts valid beats. After the DDR_BURST_LEN-th beat, go to IDLE.
  - Gaps in i_ddr_data_valid are allowed and stall the count.
- i_ddr_data_valid outside FILL is ignored, and o_l2_ddr_operate_enable stays 0.

## Timing
- Reset (i_rst_n low at an edge): next state IDLE, both counters 0.
- Every output is 0 after reset, including o_l2_l1_burst_address = 12'h000 and o_busy.
- Reset mid-burst abandons the burst with no done pulse. The L2 buffer must be reset in the same cycle.
- L1 grant latency: i_l1_req is sampled in IDLE at edge k.
  - CHECK outputs are visible after edge k+1.
  - The first o_l2_l1_operate_enable cycle follows edge k+2.
  - Total: 2 cycles of latency, plus L1_BURST_LEN data cycles.
- Refill: a refill eligible in IDLE at edge k raises o_ddr_req after edge k+1.
- o_ddr_req drops after the edge that samples i_ddr_grant. A grant arriving in the same cycle o_ddr_req first rises is valid.
- Back-to-back operation: IDLE is visited for at least one cycle between any two operations.
- An i_l1_req that falls before its ack is allowed only in IDLE. Its effect is undefined in CHECK.
- i_l2_unread_size at 0 or 4095 is handled purely by the eligibility rules: at 4095 there is no refill, and at 0 there is no L1 service.

## Test plan
- Reset with i_l2_unread_size = 0 and no requests: all outputs 0. Release reset: DDR_WAIT and o_ddr_req = 1 after one cycle.
- Refill: grant in cycle 3, data_valid pattern 1,0,1,1,1 → exactly 4 o_l2_ddr_operate_enable cycles with o_l2_ddr_rw = 1, then IDLE, o_busy = 0.
- Unread = 100, i_l1_req with address 12'h040, no conflict → address enable for 1 cycle, then 8 operate-enable cycles with o_l1_ack on the first and o_l1_burst_done on the eighth, o_l2_l1_rw = 0 throughout.
- Unread = 100, i_l1_req with conflict = 1 in CHECK → no ack, return to IDLE, retry. Drop conflict on the second attempt → burst completes.
- Unread = 20, i_l1_req and refill both eligible → refill runs first; the L1 burst starts only after FILL returns through IDLE.
- Assert i_rst_n = 0 during the 5th L1 beat → operate enable and o_busy are 0 after that edge, with no done pulse.
